keynsham_dma: RTL and testbench

//  Word-granular copy/fill engine: bus initiator on the data-bus protocol (access/addr/wr_val/
//  wr_en/bytesel -> ack/data/error) serviced by keynsham_sdram or any other responder.
//  CPU programs it through a small responder register port on the data bus; raises irq when done.

---
 rtl/keynsham_pkg.sv | 27 ++
 rtl/cs_gen.sv | 22 ++
 rtl/keynsham_dma_regs.sv | 113 +++++++++++
 rtl/keynsham_dma.sv | 160 ++++++++++++++++
 tb/tb_keynsham_dma.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keynsham_pkg.sv
`default_nettype none
// ============================================================================
// keynsham_pkg : shared constants and types for the keynsham DMA engine
// Rev 1.0
// ============================================================================
package keynsham_pkg;

   localparam logic [2:0] DMA_SRC  = 3'd0;
   localparam logic [2:0] DMA_DST  = 3'd1;
   localparam logic [2:0] DMA_LEN  = 3'd2;
   localparam logic [2:0] DMA_FILL = 3'd3;
   localparam logic [2:0] DMA_CTRL = 3'd4;

   localparam int CTRL_START  = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_DONE   = 3;
   localparam int CTRL_ERROR  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/cs_gen.sv
`default_nettype none
// ============================================================================
// cs_gen : chip-select decode of a word address against a byte window
// Rev 1.0
// ============================================================================
module cs_gen #(
   parameter logic [31:0] ADDRESS = 32'h0,
   parameter logic [31:0] SIZE    = 32'h0
) (
   input  logic [29:0] addr_i,
   output logic        cs_o
);

   logic [31:0] w_byte_addr;
   logic [31:0] w_offset;

   assign w_byte_addr = {addr_i, 2'b00};
   assign w_offset    = w_byte_addr - ADDRESS;
   assign cs_o        = (w_byte_addr >= ADDRESS) && (w_offset < SIZE);

endmodule
`default_nettype wire

// File: rtl/keynsham_dma_regs.sv
`default_nettype none
// ============================================================================
// keynsham_dma_regs : cfg port decode, ack, readback mux and CTRL/STATUS flags
// Rev 1.0
// ============================================================================
module keynsham_dma_regs
   import keynsham_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_access_i,
   input  logic        cfg_cs_i,
   input  logic [2:0]  cfg_idx_i,
   input  logic        cfg_wr_en_i,
   input  logic [31:0] cfg_wr_val_i,
   output logic        cfg_ack_o,
   output logic [31:0] cfg_data_o,
   input  logic        busy_i,
   input  logic [29:0] src_i,
   input  logic [29:0] dst_i,
   input  logic [31:0] len_i,
   input  logic        set_done_i,
   input  logic        set_error_i,
   input  logic        clr_flags_i,
   output logic        src_we_o,
   output logic        dst_we_o,
   output logic        len_we_o,
   output logic        start_o,
   output logic        start_mode_o,
   output logic [31:0] fill_o,
   output logic        mode_o,
   output logic        irq_en_o,
   output logic        done_o,
   output logic        error_o
);

   logic        cfg_ack_q;
   logic [31:0] cfg_data_q;
   logic [31:0] fill_q;
   logic        mode_q, irq_en_q, done_q, error_q;
   logic        done_d, error_d;

   logic        w_hit, w_wr, w_wr_ctrl;
   logic [31:0] w_rd_data;

   assign w_hit     = cfg_access_i & cfg_cs_i;
   assign w_wr      = w_hit & cfg_wr_en_i;
   assign w_wr_ctrl = w_wr & (cfg_idx_i == DMA_CTRL);

   assign src_we_o     = w_wr & (cfg_idx_i == DMA_SRC) & ~busy_i;
   assign dst_we_o     = w_wr & (cfg_idx_i == DMA_DST) & ~busy_i;
   assign len_we_o     = w_wr & (cfg_idx_i == DMA_LEN) & ~busy_i;
   assign start_o      = w_wr_ctrl & cfg_wr_val_i[CTRL_START] & ~busy_i;
   assign start_mode_o = cfg_wr_val_i[CTRL_MODE];

   always_comb begin
      w_rd_data = '0;
      case (cfg_idx_i)
         DMA_SRC:  w_rd_data = {2'b00, src_i};
         DMA_DST:  w_rd_data = {2'b00, dst_i};
         DMA_LEN:  w_rd_data = len_i;
         DMA_FILL: w_rd_data = fill_q;
         DMA_CTRL: w_rd_data = {27'b0, error_q, done_q, irq_en_q, mode_q, busy_i};
         default:  w_rd_data = '0;
      endcase
   end

   // Hardware events take priority over a software W1C landing in the same cycle.
   always_comb begin
      done_d  = done_q;
      error_d = error_q;
      if (w_wr_ctrl && cfg_wr_val_i[CTRL_DONE])  done_d  = 1'b0;
      if (w_wr_ctrl && cfg_wr_val_i[CTRL_ERROR]) error_d = 1'b0;
      if (clr_flags_i) begin
         done_d  = 1'b0;
         error_d = 1'b0;
      end
      if (set_done_i)  done_d  = 1'b1;
      if (set_error_i) error_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack_q  <= 1'b0;
         cfg_data_q <= '0;
         fill_q     <= '0;
         mode_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         cfg_ack_q  <= w_hit;
         cfg_data_q <= (w_hit && !cfg_wr_en_i) ? w_rd_data : '0;
         if (w_wr && (cfg_idx_i == DMA_FILL) && !busy_i) fill_q <= cfg_wr_val_i;
         if (w_wr_ctrl) begin
            irq_en_q <= cfg_wr_val_i[CTRL_IRQ_EN];
            if (!busy_i) mode_q <= cfg_wr_val_i[CTRL_MODE];
         end
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign cfg_ack_o  = cfg_ack_q;
   assign cfg_data_o = cfg_data_q;
   assign fill_o     = fill_q;
   assign mode_o     = mode_q;
   assign irq_en_o   = irq_en_q;
   assign done_o     = done_q;
   assign error_o    = error_q;

endmodule
`default_nettype wire

// File: rtl/keynsham_dma.sv
`default_nettype none
// ============================================================================
// keynsham_dma : word copy/fill bus initiator with a cfg register port
// Rev 1.0
// ============================================================================
module keynsham_dma
   import keynsham_pkg::*;
#(
   parameter logic [31:0] BUS_ADDRESS = 32'h0,
   parameter logic [31:0] BUS_SIZE    = 32'h0,
   parameter int          LEN_W       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_access,
   output logic        cfg_cs,
   input  logic [29:0] cfg_addr,
   input  logic        cfg_wr_en,
   input  logic [31:0] cfg_wr_val,
   output logic        cfg_ack,
   output logic [31:0] cfg_data,
   output logic        m_access,
   output logic [29:0] m_addr,
   output logic        m_wr_en,
   output logic [31:0] m_wr_val,
   output logic [3:0]  m_bytesel,
   input  logic        m_ack,
   input  logic        m_error,
   input  logic [31:0] m_data,
   output logic        irq
);

   dma_state_e       state_q;
   logic [29:0]      src_q, dst_q;
   logic [LEN_W-1:0] len_q;
   logic [31:0]      data_q;
   logic             m_access_q, m_wr_en_q;
   logic [29:0]      m_addr_q;
   logic [31:0]      m_wr_val_q;

   logic        w_src_we, w_dst_we, w_len_we, w_start, w_start_mode;
   logic [31:0] w_fill;
   logic        w_mode, w_irq_en, w_done, w_error;
   logic        w_busy, w_len_nz, w_beat_end, w_last, w_set_done, w_set_error, w_clr_flags;

   cs_gen #(
      .ADDRESS (BUS_ADDRESS),
      .SIZE    (BUS_SIZE)
   ) u_cs_gen (
      .addr_i  (cfg_addr),
      .cs_o    (cfg_cs)
   );

   keynsham_dma_regs u_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_access_i (cfg_access),
      .cfg_cs_i     (cfg_cs),
      .cfg_idx_i    (cfg_addr[2:0]),
      .cfg_wr_en_i  (cfg_wr_en),
      .cfg_wr_val_i (cfg_wr_val),
      .cfg_ack_o    (cfg_ack),
      .cfg_data_o   (cfg_data),
      .busy_i       (w_busy),
      .src_i        (src_q),
      .dst_i        (dst_q),
      .len_i        (32'(len_q)),
      .set_done_i   (w_set_done),
      .set_error_i  (w_set_error),
      .clr_flags_i  (w_clr_flags),
      .src_we_o     (w_src_we),
      .dst_we_o     (w_dst_we),
      .len_we_o     (w_len_we),
      .start_o      (w_start),
      .start_mode_o (w_start_mode),
      .fill_o       (w_fill),
      .mode_o       (w_mode),
      .irq_en_o     (w_irq_en),
      .done_o       (w_done),
      .error_o      (w_error)
   );

   assign w_busy      = (state_q != ST_IDLE);
   assign w_len_nz    = (len_q != '0);
   assign w_beat_end  = m_access_q & m_ack & w_busy;
   assign w_last      = (state_q == ST_WR) && (len_q == LEN_W'(1));
   assign w_set_error = w_beat_end & m_error;
   assign w_set_done  = (w_start & ~w_len_nz) | (w_beat_end & (m_error | w_last));
   assign w_clr_flags = w_start & w_len_nz;

   // Each beat raises m_access from a cycle where it was low, so a gap cycle
   // always separates consecutive beats and m_ack is only honoured while requesting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         data_q     <= '0;
         m_access_q <= 1'b0;
         m_addr_q   <= '0;
         m_wr_en_q  <= 1'b0;
         m_wr_val_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_src_we) src_q <= cfg_wr_val[29:0];
               if (w_dst_we) dst_q <= cfg_wr_val[29:0];
               if (w_len_we) len_q <= cfg_wr_val[LEN_W-1:0];
               if (w_start && w_len_nz) state_q <= w_start_mode ? ST_WR : ST_RD;
            end
            ST_RD: begin
               if (!m_access_q) begin
                  m_access_q <= 1'b1;
                  m_addr_q   <= src_q;
                  m_wr_en_q  <= 1'b0;
               end else if (m_ack) begin
                  m_access_q <= 1'b0;
                  if (m_error) begin
                     state_q <= ST_IDLE;
                  end else begin
                     data_q  <= m_data;
                     src_q   <= src_q + 30'd1;
                     state_q <= ST_WR;
                  end
               end
            end
            ST_WR: begin
               if (!m_access_q) begin
                  m_access_q <= 1'b1;
                  m_addr_q   <= dst_q;
                  m_wr_en_q  <= 1'b1;
                  m_wr_val_q <= w_mode ? w_fill : data_q;
               end else if (m_ack) begin
                  m_access_q <= 1'b0;
                  m_wr_en_q  <= 1'b0;
                  if (m_error) begin
                     state_q <= ST_IDLE;
                  end else begin
                     dst_q <= dst_q + 30'd1;
                     len_q <= len_q - LEN_W'(1);
                     if (w_last)       state_q <= ST_IDLE;
                     else if (!w_mode) state_q <= ST_RD;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_access  = m_access_q;
   assign m_addr    = m_addr_q;
   assign m_wr_en   = m_wr_en_q;
   assign m_wr_val  = m_wr_val_q;
   assign m_bytesel = 4'b1111;
   assign irq       = w_done & w_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_keynsham_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_keynsham_dma : directed register vectors plus copy/fill/error/reset sequences
// Rev 1.0
// ============================================================================
module tb_keynsham_dma;
   import keynsham_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam logic [29:0] REG_W = 30'h2000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_access, cfg_cs, cfg_wr_en, cfg_ack;
   logic [29:0] cfg_addr;
   logic [31:0] cfg_wr_val, cfg_data;
   logic        m_access, m_wr_en, m_ack, m_error, irq;
   logic [29:0] m_addr;
   logic [31:0] m_wr_val, m_data;
   logic [3:0]  m_bytesel;

   always #5 clk = ~clk;

   keynsham_dma #(
      .BUS_ADDRESS (BASE),
      .BUS_SIZE    (32'h20),
      .LEN_W       (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_access (cfg_access),
      .cfg_cs     (cfg_cs),
      .cfg_addr   (cfg_addr),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_wr_val (cfg_wr_val),
      .cfg_ack    (cfg_ack),
      .cfg_data   (cfg_data),
      .m_access   (m_access),
      .m_addr     (m_addr),
      .m_wr_en    (m_wr_en),
      .m_wr_val   (m_wr_val),
      .m_bytesel  (m_bytesel),
      .m_ack      (m_ack),
      .m_error    (m_error),
      .m_data     (m_data),
      .irq        (irq)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Responder model: one-cycle registered ack, read data is a function of address.
   function automatic logic [31:0] memval(input logic [29:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   logic [29:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [29:0] rd_addr_q[$];
   int          wr_cnt = 0;
   int          err_at = -1;
   int          bytesel_bad = 0;
   int          acc_cycles = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ack   <= 1'b0;
         m_error <= 1'b0;
         m_data  <= '0;
      end else begin
         m_ack   <= 1'b0;
         m_error <= 1'b0;
         m_data  <= '0;
         if (m_access && !m_ack) begin
            m_ack <= 1'b1;
            if (m_bytesel != 4'hF) bytesel_bad++;
            if (m_wr_en) begin
               wr_addr_q.push_back(m_addr);
               wr_data_q.push_back(m_wr_val);
               if (wr_cnt == err_at) m_error <= 1'b1;
               wr_cnt++;
            end else begin
               rd_addr_q.push_back(m_addr);
               m_data <= memval(m_addr);
            end
         end
      end
   end

   always @(posedge clk) if (m_access) acc_cycles++;

   task automatic cfg_op(input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                         output logic [31:0] rd);
      cfg_access = 1'b1;
      cfg_addr   = REG_W + {27'b0, idx};
      cfg_wr_en  = wr;
      cfg_wr_val = wd;
      @(negedge clk);
      cfg_access = 1'b0;
      cfg_wr_en  = 1'b0;
      rd = cfg_data;
      check("cfg_ack", {31'b0, cfg_ack}, 32'h1);
   endtask

   task automatic cfg_wr(input logic [2:0] idx, input logic [31:0] wd);
      logic [31:0] dummy;
      cfg_op(1'b1, idx, wd, dummy);
   endtask

   task automatic cfg_rd(input logic [2:0] idx, output logic [31:0] rd);
      cfg_op(1'b0, idx, 32'h0, rd);
   endtask

   task automatic wait_done(input string tag);
      logic [31:0] st;
      int n;
      n  = 0;
      st = 32'h1;
      while (st[0] && n < 200) begin
         cfg_rd(DMA_CTRL, st);
         n++;
      end
      check({tag, "_finished"}, {31'b0, st[0]}, 32'h0);
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
   endtask

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vec[10];

   initial begin
      logic [31:0] rd;
      int acc0;
      int found;

      vec[0] = '{DMA_SRC,  32'hFFFF_FFFF, 32'h3FFF_FFFF};
      vec[1] = '{DMA_SRC,  32'h0000_0123, 32'h0000_0123};
      vec[2] = '{DMA_DST,  32'h4000_0456, 32'h0000_0456};
      vec[3] = '{DMA_LEN,  32'h0001_2345, 32'h0000_2345};
      vec[4] = '{DMA_FILL, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vec[5] = '{DMA_CTRL, 32'h0000_0006, 32'h0000_0006};
      vec[6] = '{DMA_CTRL, 32'h0000_0000, 32'h0000_0000};
      vec[7] = '{3'd5,     32'hFFFF_FFFF, 32'h0000_0000};
      vec[8] = '{3'd7,     32'h1234_5678, 32'h0000_0000};
      vec[9] = '{DMA_LEN,  32'h0000_0000, 32'h0000_0000};

      cfg_access = 1'b0;
      cfg_addr   = REG_W;
      cfg_wr_en  = 1'b0;
      cfg_wr_val = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_m_access", {31'b0, m_access}, 32'h0);
      check("rst_cfg_ack",  {31'b0, cfg_ack},  32'h0);
      check("rst_irq",      {31'b0, irq},      32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_rd(DMA_CTRL, rd); check("rst_status", rd, 32'h0);
      cfg_rd(DMA_SRC,  rd); check("rst_src",    rd, 32'h0);
      cfg_rd(DMA_LEN,  rd); check("rst_len",    rd, 32'h0);

      // Register file vectors
      for (int i = 0; i < 10; i++) begin
         cfg_wr(vec[i].idx, vec[i].wdata);
         cfg_rd(vec[i].idx, rd);
         check($sformatf("reg_vec%0d", i), rd, vec[i].exp);
      end

      // Window decode
      cfg_access = 1'b1;
      cfg_addr   = REG_W + 30'd8;
      #1 check("cs_outside", {31'b0, cfg_cs}, 32'h0);
      @(negedge clk);
      cfg_access = 1'b0;
      check("ack_outside", {31'b0, cfg_ack}, 32'h0);
      cfg_addr = REG_W + 30'd4;
      #1 check("cs_inside", {31'b0, cfg_cs}, 32'h1);
      @(negedge clk);

      // Copy
      clear_logs();
      cfg_wr(DMA_SRC, 32'h100);
      cfg_wr(DMA_DST, 32'h200);
      cfg_wr(DMA_LEN, 32'd4);
      cfg_wr(DMA_CTRL, 32'h1);
      wait_done("copy");
      check("copy_nrd", rd_addr_q.size(), 32'd4);
      check("copy_nwr", wr_addr_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
         check($sformatf("copy_rd_addr%0d", i), {2'b00, rd_addr_q[i]}, 32'h100 + i);
         check($sformatf("copy_wr_addr%0d", i), {2'b00, wr_addr_q[i]}, 32'h200 + i);
         check($sformatf("copy_wr_data%0d", i), wr_data_q[i], memval(30'h100 + 30'(i)));
      end
      cfg_rd(DMA_CTRL, rd); check("copy_status", rd, 32'h8);
      cfg_rd(DMA_LEN,  rd); check("copy_len",    rd, 32'h0);
      cfg_rd(DMA_SRC,  rd); check("copy_src",    rd, 32'h104);
      cfg_rd(DMA_DST,  rd); check("copy_dst",    rd, 32'h204);

      // Fill with irq
      clear_logs();
      cfg_wr(DMA_FILL, 32'hDEAD_BEEF);
      cfg_wr(DMA_DST,  32'h40);
      cfg_wr(DMA_LEN,  32'd3);
      cfg_wr(DMA_CTRL, 32'h7);
      wait_done("fill");
      check("fill_nrd", rd_addr_q.size(), 32'd0);
      check("fill_nwr", wr_addr_q.size(), 32'd3);
      for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
         check($sformatf("fill_addr%0d", i), {2'b00, wr_addr_q[i]}, 32'h40 + i);
         check($sformatf("fill_data%0d", i), wr_data_q[i], 32'hDEAD_BEEF);
      end
      check("fill_irq", {31'b0, irq}, 32'h1);
      cfg_rd(DMA_CTRL, rd); check("fill_status", rd, 32'hE);
      cfg_wr(DMA_CTRL, 32'h08);
      check("fill_irq_cleared", {31'b0, irq}, 32'h0);
      cfg_rd(DMA_CTRL, rd); check("fill_w1c_status", rd, 32'h0);

      // Zero length
      cfg_wr(DMA_LEN, 32'd0);
      acc0 = acc_cycles;
      cfg_wr(DMA_CTRL, 32'h1);
      cfg_rd(DMA_CTRL, rd); check("len0_status", rd, 32'h8);
      repeat (5) @(negedge clk);
      check("len0_no_access", acc_cycles, acc0);
      cfg_wr(DMA_CTRL, 32'h08);

      // Error on second write beat
      clear_logs();
      err_at = wr_cnt + 1;
      cfg_wr(DMA_SRC, 32'h300);
      cfg_wr(DMA_DST, 32'h500);
      cfg_wr(DMA_LEN, 32'd5);
      cfg_wr(DMA_CTRL, 32'h5);
      wait_done("err");
      err_at = -1;
      check("err_nwr", wr_addr_q.size(), 32'd2);
      cfg_rd(DMA_CTRL, rd); check("err_status", rd, 32'h1C);
      cfg_rd(DMA_LEN,  rd); check("err_len",    rd, 32'd4);
      cfg_rd(DMA_DST,  rd); check("err_dst",    rd, 32'h501);
      cfg_rd(DMA_SRC,  rd); check("err_src",    rd, 32'h302);
      check("err_irq", {31'b0, irq}, 32'h1);
      cfg_wr(DMA_CTRL, 32'h18);
      check("err_irq_cleared", {31'b0, irq}, 32'h0);
      cfg_rd(DMA_CTRL, rd); check("err_w1c_status", rd, 32'h0);

      // Writes and restart while busy
      clear_logs();
      cfg_wr(DMA_SRC, 32'h100);
      cfg_wr(DMA_DST, 32'h600);
      cfg_wr(DMA_LEN, 32'd4);
      cfg_wr(DMA_CTRL, 32'h1);
      repeat (3) @(negedge clk);
      cfg_wr(DMA_SRC, 32'h999);
      cfg_wr(DMA_CTRL, 32'h1);
      cfg_rd(DMA_SRC, rd);
      check("busy_src_kept", {31'b0, rd == 32'h999}, 32'h0);
      wait_done("busy");
      check("busy_nwr", wr_addr_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
         check($sformatf("busy_wr_addr%0d", i), {2'b00, wr_addr_q[i]}, 32'h600 + i);
         check($sformatf("busy_wr_data%0d", i), wr_data_q[i], memval(30'h100 + 30'(i)));
      end
      cfg_rd(DMA_SRC, rd); check("busy_src_final", rd, 32'h104);
      cfg_rd(DMA_LEN, rd); check("busy_len_final", rd, 32'h0);

      // Destination wrap
      clear_logs();
      cfg_wr(DMA_FILL, 32'h1234_5678);
      cfg_wr(DMA_DST,  32'h3FFF_FFFF);
      cfg_wr(DMA_LEN,  32'd2);
      cfg_wr(DMA_CTRL, 32'h3);
      wait_done("wrap");
      check("wrap_nwr", wr_addr_q.size(), 32'd2);
      if (wr_addr_q.size() == 2) begin
         check("wrap_addr0", {2'b00, wr_addr_q[0]}, 32'h3FFF_FFFF);
         check("wrap_addr1", {2'b00, wr_addr_q[1]}, 32'h0);
         check("wrap_data1", wr_data_q[1], 32'h1234_5678);
      end
      cfg_rd(DMA_DST,  rd); check("wrap_dst", rd, 32'h1);
      cfg_rd(DMA_CTRL, rd); check("wrap_status", rd, 32'hA);

      // Asynchronous reset during a read beat
      cfg_wr(DMA_SRC,  32'h100);
      cfg_wr(DMA_DST,  32'h700);
      cfg_wr(DMA_LEN,  32'd3);
      cfg_wr(DMA_CTRL, 32'h5);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (m_access && !m_wr_en) found = 1;
      end
      check("arst_saw_read", found, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_m_access", {31'b0, m_access}, 32'h0);
      check("arst_cfg_ack",  {31'b0, cfg_ack},  32'h0);
      check("arst_irq",      {31'b0, irq},      32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_rd(DMA_CTRL, rd); check("arst_status", rd, 32'h0);
      cfg_rd(DMA_SRC,  rd); check("arst_src",    rd, 32'h0);
      cfg_rd(DMA_LEN,  rd); check("arst_len",    rd, 32'h0);
      check("arst_idle_bus", {31'b0, m_access}, 32'h0);

      check("bytesel_all", bytesel_bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
